rps_match_controller: RTL

//  Sequences a two-player rock-paper-scissors match over the one-hot move datapath.

---
 rtl/rps_pkg.sv | 28 ++
 rtl/rps_match_controller_if.sv | 35 +++
 rtl/rps_judge.sv | 42 ++++
 rtl/rps_match_controller.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared move encodings, round results and controller states for the rock-paper-scissors match logic.
package rps_pkg;

   localparam logic [2:0] MOVE_SCISSORS = 3'b001;
   localparam logic [2:0] MOVE_ROCK     = 3'b010;
   localparam logic [2:0] MOVE_PAPER    = 3'b100;

   typedef enum logic [1:0] {
      TIE   = 2'b00,
      A_WIN = 2'b01,
      B_WIN = 2'b10,
      VOID  = 2'b11
   } res_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      JUDGE   = 3'd2,
      REPORT  = 3'd3,
      DONE    = 3'd4
   } state_e;

   // Only the three defined one-hot codes count as playable moves
   function automatic logic is_onehot3(input logic [2:0] m);
      return (m == MOVE_SCISSORS) || (m == MOVE_ROCK) || (m == MOVE_PAPER);
   endfunction

endpackage

// File: rtl/rps_match_controller_if.sv
// Player-facing handshake and score/status bundle of the match controller.
interface rps_match_controller_if #(
   parameter int WIN_TARGET = 2
);

   localparam int SW = $clog2(WIN_TARGET + 1);

   logic          start;
   logic          a_valid;
   logic [2:0]    a_move;
   logic          a_ready;
   logic          b_valid;
   logic [2:0]    b_move;
   logic          b_ready;
   logic          round_done;
   logic [1:0]    round_result;
   logic [SW-1:0] score_a;
   logic [SW-1:0] score_b;
   logic          busy;
   logic          match_done;
   logic [1:0]    match_winner;

   modport master (
      output start, a_valid, a_move, b_valid, b_move,
      input  a_ready, b_ready, round_done, round_result,
             score_a, score_b, busy, match_done, match_winner
   );

   modport slave (
      input  start, a_valid, a_move, b_valid, b_move,
      output a_ready, b_ready, round_done, round_result,
             score_a, score_b, busy, match_done, match_winner
   );

endinterface

// File: rtl/rps_judge.sv
// Combinational round referee: turns the two captured moves into a tie/win/void verdict.
module rps_judge
   import rps_pkg::*;
(
   input  logic [2:0] aMove,
   input  logic [2:0] bMove,
   input  logic       aVld,
   input  logic       bVld,
   output res_e       result
);

   function automatic logic checkTie(input logic [2:0] x, input logic [2:0] y);
      return x == y;
   endfunction

   logic aOk;
   logic bOk;
   logic aBeats;

   // With this one-hot order each move beats the one rotated one place below it,
   // and a missing or illegal move hands the round to a legal opponent
   always_comb begin
      aOk    = aVld && is_onehot3(aMove);
      bOk    = bVld && is_onehot3(bMove);
      aBeats = (aMove == {bMove[1:0], bMove[2]});
      result = VOID;
      if (aOk && bOk) begin
         if (checkTie(aMove, bMove)) begin
            result = TIE;
         end else if (aBeats) begin
            result = A_WIN;
         end else begin
            result = B_WIN;
         end
      end else if (aOk) begin
         result = A_WIN;
      end else if (bOk) begin
         result = B_WIN;
      end
   end

endmodule

// File: rtl/rps_match_controller.sv
// Match sequencer: collects one move per player each round, judges it, keeps score
// and declares the winner once a player reaches WIN_TARGET round wins.
module rps_match_controller
   import rps_pkg::*;
#(
   parameter int WIN_TARGET  = 2,
   parameter int TIMEOUT_CYC = 255
)
(
   input logic                 clk,
   input logic                 rst,
   rps_match_controller_if.slave bus
);

   localparam int SW = $clog2(WIN_TARGET + 1);
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [SW-1:0] SCORE_MAX  = SW'(WIN_TARGET);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

   state_e        state;
   logic          aCap;
   logic          bCap;
   logic [2:0]    aMoveReg;
   logic [2:0]    bMoveReg;
   logic [TW-1:0] timer;
   logic [SW-1:0] scoreA;
   logic [SW-1:0] scoreB;
   res_e          roundResult;
   logic          roundDone;
   logic          aReady;
   logic          bReady;
   logic          busy;
   logic          matchDone;
   logic [1:0]    matchWinner;
   res_e          judgeRes;
   logic          aTake;
   logic          bTake;

   assign aTake = bus.a_valid && aReady;
   assign bTake = bus.b_valid && bReady;

   rps_judge judgeInst (
      .aMove  (aMoveReg),
      .bMove  (bMoveReg),
      .aVld   (aCap),
      .bVld   (bCap),
      .result (judgeRes)
   );

   // Whole controller in one registered FSM; every output is a flop so players
   // and the display logic never see combinational glitches
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         aCap        <= 1'b0;
         bCap        <= 1'b0;
         aMoveReg    <= '0;
         bMoveReg    <= '0;
         timer       <= '0;
         scoreA      <= '0;
         scoreB      <= '0;
         roundResult <= TIE;
         roundDone   <= 1'b0;
         aReady      <= 1'b0;
         bReady      <= 1'b0;
         busy        <= 1'b0;
         matchDone   <= 1'b0;
         matchWinner <= 2'b00;
      end else begin
         roundDone <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state       <= COLLECT;
                  aCap        <= 1'b0;
                  bCap        <= 1'b0;
                  aMoveReg    <= '0;
                  bMoveReg    <= '0;
                  timer       <= '0;
                  scoreA      <= '0;
                  scoreB      <= '0;
                  aReady      <= 1'b1;
                  bReady      <= 1'b1;
                  busy        <= 1'b1;
                  matchDone   <= 1'b0;
                  matchWinner <= 2'b00;
               end
            end
            COLLECT: begin
               if (aTake) begin
                  aCap     <= 1'b1;
                  aMoveReg <= bus.a_move;
                  aReady   <= 1'b0;
               end
               if (bTake) begin
                  bCap     <= 1'b1;
                  bMoveReg <= bus.b_move;
                  bReady   <= 1'b0;
               end
               // A capture landing on the last allowed cycle still counts in the verdict
               if (((aCap || aTake) && (bCap || bTake)) || (timer == TIMER_LAST)) begin
                  state  <= JUDGE;
                  aReady <= 1'b0;
                  bReady <= 1'b0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            JUDGE: begin
               roundResult <= judgeRes;
               roundDone   <= 1'b1;
               if ((judgeRes == A_WIN) && (scoreA != SCORE_MAX)) begin
                  scoreA <= scoreA + SW'(1);
               end
               if ((judgeRes == B_WIN) && (scoreB != SCORE_MAX)) begin
                  scoreB <= scoreB + SW'(1);
               end
               state <= REPORT;
            end
            REPORT: begin
               if ((scoreA == SCORE_MAX) || (scoreB == SCORE_MAX)) begin
                  state       <= DONE;
                  busy        <= 1'b0;
                  matchDone   <= 1'b1;
                  matchWinner <= (scoreA == SCORE_MAX) ? 2'b01 : 2'b10;
               end else begin
                  state    <= COLLECT;
                  aCap     <= 1'b0;
                  bCap     <= 1'b0;
                  aMoveReg <= '0;
                  bMoveReg <= '0;
                  timer    <= '0;
                  aReady   <= 1'b1;
                  bReady   <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.a_ready      = aReady;
   assign bus.b_ready      = bReady;
   assign bus.round_done   = roundDone;
   assign bus.round_result = roundResult;
   assign bus.score_a      = scoreA;
   assign bus.score_b      = scoreB;
   assign bus.busy         = busy;
   assign bus.match_done   = matchDone;
   assign bus.match_winner = matchWinner;

endmodule
